// File: rtl/qea_pkg.sv
// ----------------------------------------------------------------------------
// qea_pkg : shared widths, Q2.30 constant and loader FSM state type
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package qea_pkg;

    localparam int QEA_PE_NUM_WIDTH     = 2;
    localparam int QEA_PE_NUM           = 4;
    localparam int QEA_STATE_DATA_WIDTH = 64;
    localparam int QEA_STATE_ADDR_WIDTH = 16;
    localparam int QEA_CTX_DATA_WIDTH   = 64;
    localparam int QEA_CTX_ADDR_WIDTH   = 16;
    localparam int QEA_MAX_QBIT_WIDTH   = 6;

    localparam logic [31:0] Q230_ONE = 32'h4000_0000;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD_CTX   = 3'd1,
        ST_INIT_STATE = 3'd2,
        ST_START      = 3'd3,
        ST_RUN        = 3'd4,
        ST_RD_REQ     = 3'd5,
        ST_RD_WAIT    = 3'd6,
        ST_RD_OUT     = 3'd7
    } qea_state_t;

endpackage

`default_nettype wire

// File: rtl/qea_res_holdreg.sv
// ----------------------------------------------------------------------------
// qea_res_holdreg : one-entry valid/ready holding register for readback data
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module qea_res_holdreg
    import qea_pkg::*;
#(
    parameter int WIDTH = QEA_PE_NUM * QEA_STATE_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_last
);

    // Data and last only change on load, so they stay stable across a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_last  <= 1'b0;
        end else if (load) begin
            res_valid <= 1'b1;
            res_data  <= load_data;
            res_last  <= load_last;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/qea_host_loader.sv
// ----------------------------------------------------------------------------
// qea_host_loader : loads gate context, initialises |0>, starts QEA, streams state
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module qea_host_loader
    import qea_pkg::*;
#(
    parameter int PE_NUM_WIDTH            = QEA_PE_NUM_WIDTH,
    parameter int PE_NUM                  = QEA_PE_NUM,
    parameter int STATE_DATA_WIDTH        = QEA_STATE_DATA_WIDTH,
    parameter int STATE_ADDR_WIDTH        = QEA_STATE_ADDR_WIDTH,
    parameter int GATE_CONTEXT_DATA_WIDTH = QEA_CTX_DATA_WIDTH,
    parameter int GATE_CONTEXT_ADDR_WIDTH = QEA_CTX_ADDR_WIDTH,
    parameter int MAX_QBIT_WIDTH          = QEA_MAX_QBIT_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_cfg_valid,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_cfg_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_cfg_ins_num,
    output logic                                 o_cfg_ready,
    input  logic                                 i_ctx_s_valid,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_s_data,
    output logic                                 o_ctx_s_ready,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic                                 o_state_ena,
    output logic                                 o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
    output logic                                 o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
    input  logic                                 i_qea_complete,
    output logic                                 o_res_valid,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_res_data,
    output logic                                 o_res_last,
    input  logic                                 i_res_ready,
    output logic                                 o_busy,
    output logic                                 o_cfg_err
);

    localparam int SW  = PE_NUM * STATE_DATA_WIDTH;
    localparam int SAW = STATE_ADDR_WIDTH;
    localparam int CAW = GATE_CONTEXT_ADDR_WIDTH;

    localparam logic [STATE_DATA_WIDTH-1:0] ONE_LANE =
        {Q230_ONE, {(STATE_DATA_WIDTH-32){1'b0}}};
    localparam logic [SW-1:0] INIT0 = SW'(ONE_LANE) << ((PE_NUM-1)*STATE_DATA_WIDTH);
    localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MIN = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MAX = MAX_QBIT_WIDTH'(SAW + PE_NUM_WIDTH);

    qea_state_t                state;
    logic [CAW:0]              ctx_cnt;
    logic [CAW:0]              ins_last;
    logic [SAW:0]              addr_cnt;
    logic [SAW:0]              last_addr;
    logic                      run_first;
    logic                      cap;

    logic                      cfg_bad;
    logic [MAX_QBIT_WIDTH-1:0] depth_log2;
    logic [SAW:0]              last_addr_nxt;
    logic                      ctx_hs;
    logic                      res_hs;

    assign cfg_bad = (i_cfg_ins_num == '0)
                   || (i_cfg_ins_num[CAW] && |i_cfg_ins_num[CAW-1:0])
                   || (i_cfg_qbit_num < QBIT_MIN)
                   || (i_cfg_qbit_num > QBIT_MAX);

    // Counters are one bit wider than the port so depth 2^SAW is representable.
    assign depth_log2    = i_cfg_qbit_num - QBIT_MIN;
    assign last_addr_nxt = ((SAW+1)'(1) << depth_log2) - (SAW+1)'(1);

    assign ctx_hs     = o_ctx_s_ready && i_ctx_s_valid;
    assign o_ctx_en   = ctx_hs;
    assign o_ctx_wea  = ctx_hs;
    assign o_ctx_addr = ctx_hs ? ctx_cnt[CAW-1:0] : '0;
    assign o_ctx_data = ctx_hs ? i_ctx_s_data : '0;

    assign res_hs = o_res_valid && i_res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            ctx_cnt        <= '0;
            ins_last       <= '0;
            addr_cnt       <= '0;
            last_addr      <= '0;
            run_first      <= 1'b0;
            cap            <= 1'b0;
            o_cfg_ready    <= 1'b1;
            o_ctx_s_ready  <= 1'b0;
            o_state_ena    <= 1'b0;
            o_state_wea    <= 1'b0;
            o_state_addra  <= '0;
            o_state_dina   <= '0;
            o_qea_start    <= 1'b0;
            o_qea_qbit_num <= '0;
            o_busy         <= 1'b0;
            o_cfg_err      <= 1'b0;
        end else begin
            o_cfg_err   <= 1'b0;
            o_qea_start <= 1'b0;
            o_state_ena <= 1'b0;
            o_state_wea <= 1'b0;
            cap         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_cfg_valid) begin
                        if (cfg_bad) begin
                            o_cfg_err <= 1'b1;
                        end else begin
                            o_qea_qbit_num <= i_cfg_qbit_num;
                            ins_last       <= i_cfg_ins_num - (CAW+1)'(1);
                            last_addr      <= last_addr_nxt;
                            ctx_cnt        <= '0;
                            o_ctx_s_ready  <= 1'b1;
                            o_cfg_ready    <= 1'b0;
                            o_busy         <= 1'b1;
                            state          <= ST_LOAD_CTX;
                        end
                    end
                end
                ST_LOAD_CTX: begin
                    if (ctx_hs) begin
                        ctx_cnt <= ctx_cnt + (CAW+1)'(1);
                        if (ctx_cnt == ins_last) begin
                            o_ctx_s_ready <= 1'b0;
                            addr_cnt      <= '0;
                            state         <= ST_INIT_STATE;
                        end
                    end
                end
                ST_INIT_STATE: begin
                    o_state_ena   <= 1'b1;
                    o_state_wea   <= 1'b1;
                    o_state_addra <= addr_cnt[SAW-1:0];
                    o_state_dina  <= (addr_cnt == '0) ? INIT0 : '0;
                    addr_cnt      <= addr_cnt + (SAW+1)'(1);
                    if (addr_cnt == last_addr) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    o_qea_start <= 1'b1;
                    run_first   <= 1'b1;
                    state       <= ST_RUN;
                end
                ST_RUN: begin
                    // Completion is a level; the cycle carrying the start pulse is skipped.
                    run_first <= 1'b0;
                    if (!run_first && i_qea_complete) begin
                        addr_cnt <= '0;
                        state    <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    o_state_ena   <= 1'b1;
                    o_state_addra <= addr_cnt[SAW-1:0];
                    state         <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    cap   <= 1'b1;
                    state <= ST_RD_OUT;
                end
                ST_RD_OUT: begin
                    if (res_hs) begin
                        if (o_res_last) begin
                            o_qea_qbit_num <= '0;
                            o_cfg_ready    <= 1'b1;
                            o_busy         <= 1'b0;
                            state          <= ST_IDLE;
                        end else begin
                            addr_cnt <= addr_cnt + (SAW+1)'(1);
                            state    <= ST_RD_REQ;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    qea_res_holdreg #(
        .WIDTH(SW)
    ) u_res_holdreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (cap),
        .load_data (i_state_dout),
        .load_last (addr_cnt == last_addr),
        .res_ready (i_res_ready),
        .res_valid (o_res_valid),
        .res_data  (o_res_data),
        .res_last  (o_res_last)
    );

endmodule

`default_nettype wire

// File: tb/tb_qea_host_loader.sv
// ----------------------------------------------------------------------------
// tb_qea_host_loader : directed bench with QEA/state-RAM model and stream sinks
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_qea_host_loader;

    localparam logic [255:0] INIT0 = {64'h40000000_00000000, 192'h0};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_cfg_valid = 1'b0;
    logic [5:0]   i_cfg_qbit_num = '0;
    logic [16:0]  i_cfg_ins_num = '0;
    logic         o_cfg_ready;
    logic         i_ctx_s_valid = 1'b0;
    logic [63:0]  i_ctx_s_data = '0;
    logic         o_ctx_s_ready;
    logic         o_ctx_en, o_ctx_wea;
    logic [15:0]  o_ctx_addr;
    logic [63:0]  o_ctx_data;
    logic         o_state_ena, o_state_wea;
    logic [15:0]  o_state_addra;
    logic [255:0] o_state_dina;
    logic [255:0] i_state_dout;
    logic         o_qea_start;
    logic [5:0]   o_qea_qbit_num;
    logic         i_qea_complete;
    logic         o_res_valid;
    logic [255:0] o_res_data;
    logic         o_res_last;
    logic         i_res_ready = 1'b0;
    logic         o_busy, o_cfg_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    qea_host_loader dut (
        .clk(clk), .rst_n(rst_n),
        .i_cfg_valid(i_cfg_valid), .i_cfg_qbit_num(i_cfg_qbit_num),
        .i_cfg_ins_num(i_cfg_ins_num), .o_cfg_ready(o_cfg_ready),
        .i_ctx_s_valid(i_ctx_s_valid), .i_ctx_s_data(i_ctx_s_data),
        .o_ctx_s_ready(o_ctx_s_ready),
        .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr),
        .o_ctx_data(o_ctx_data),
        .o_state_ena(o_state_ena), .o_state_wea(o_state_wea),
        .o_state_addra(o_state_addra), .o_state_dina(o_state_dina),
        .i_state_dout(i_state_dout),
        .o_qea_start(o_qea_start), .o_qea_qbit_num(o_qea_qbit_num),
        .i_qea_complete(i_qea_complete),
        .o_res_valid(o_res_valid), .o_res_data(o_res_data), .o_res_last(o_res_last),
        .i_res_ready(i_res_ready),
        .o_busy(o_busy), .o_cfg_err(o_cfg_err)
    );

    function automatic logic [63:0] ctxw(input int i);
        return {32'hC7C7_0000 + 32'(i), 32'(i * 7 + 5)};
    endfunction

    function automatic logic [255:0] pat(input int a);
        return {32'hDA7A_0000 + 32'(a), 32'(a * 3 + 1), 32'h1111_0000 + 32'(a),
                32'hFFFF_0000 ^ 32'(a), 64'(a) << 8, 64'h0123_4567_0000_0000 | 64'(a)};
    endfunction

    // State RAM (one-cycle read latency) and QEA model that rewrites it on start.
    logic [255:0] smem [0:255];
    logic [255:0] sdout = '0;
    int qcnt = 0;
    assign i_state_dout   = sdout;
    assign i_qea_complete = (qcnt == 1);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_qea_start) begin
            for (int a = 0; a < 256; a++) smem[a] <= pat(a);
        end else if (o_state_ena) begin
            if (o_state_wea) smem[o_state_addra[7:0]] <= o_state_dina;
            else sdout <= smem[o_state_addra[7:0]];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) qcnt <= 0;
        else if (o_qea_start) qcnt <= 50;
        else if (qcnt > 0) qcnt <= qcnt - 1;
    end

    logic [15:0]  ctx_addr_log [0:1023];
    logic [63:0]  ctx_data_log [0:1023];
    logic [15:0]  sw_addr_log  [0:1023];
    logic [255:0] sw_data_log  [0:1023];
    int ctx_n = 0, sw_n = 0, start_n = 0, start_cyc = 0, rd_cyc = -1, ctx_bad = 0;
    logic [5:0] start_qbit = '0;

    always @(posedge clk) begin
        if (o_ctx_en != o_ctx_wea) ctx_bad <= ctx_bad + 1;
        if (o_ctx_en) begin
            if (ctx_n < 1024) begin
                ctx_addr_log[ctx_n] <= o_ctx_addr;
                ctx_data_log[ctx_n] <= o_ctx_data;
            end
            ctx_n <= ctx_n + 1;
        end
        if (o_state_ena && o_state_wea) begin
            if (sw_n < 1024) begin
                sw_addr_log[sw_n] <= o_state_addra;
                sw_data_log[sw_n] <= o_state_dina;
            end
            sw_n <= sw_n + 1;
        end
        if (o_qea_start) begin
            start_n    <= start_n + 1;
            start_cyc  <= cyc;
            start_qbit <= o_qea_qbit_num;
            rd_cyc     <= -1;
        end else if (o_state_ena && !o_state_wea && rd_cyc < 0) begin
            rd_cyc <= cyc;
        end
    end

    task automatic run_job(input int qbit, input int ins, input bit rnd_ready, input string tag);
        int d = 1 << (qbit - 2);
        int c0 = ctx_n, s0 = sw_n, st0 = start_n;
        int idx = 0, got = 0, guard = 0;
        bit hs, prev_stall = 0;
        logic [255:0] prev_data = '0;
        @(negedge clk);
        checks++;
        if (o_cfg_ready !== 1'b1) begin
            failures++; $display("FAIL %s cfg_ready before job: got %b want 1", tag, o_cfg_ready);
        end
        i_cfg_valid = 1'b1; i_cfg_qbit_num = 6'(qbit); i_cfg_ins_num = 17'(ins);
        @(negedge clk);
        i_cfg_valid = 1'b0;
        checks++;
        if ({o_busy, o_cfg_ready, o_qea_qbit_num} !== {2'b10, 6'(qbit)}) begin
            failures++; $display("FAIL %s accept: busy/ready/qbit got %b/%b/%0d want 1/0/%0d",
                                 tag, o_busy, o_cfg_ready, o_qea_qbit_num, qbit);
        end
        while (idx < ins && guard < 5000) begin
            @(negedge clk); guard++;
            i_ctx_s_valid = ($urandom_range(0, 2) != 0);
            i_ctx_s_data  = ctxw(idx);
            hs = i_ctx_s_valid && o_ctx_s_ready;
            @(posedge clk);
            if (hs) idx++;
        end
        // Junk presented outside LOAD_CTX must never be consumed.
        @(negedge clk);
        i_ctx_s_valid = 1'b1; i_ctx_s_data = 64'hBAD0_BAD0_BAD0_BAD0;
        guard = 0;
        while (got < d && guard < 20000) begin
            if (prev_stall) begin
                checks++;
                if (!o_res_valid || o_res_data !== prev_data) begin
                    failures++; $display("FAIL %s stall hold: valid %b data %h want 1 %h",
                                         tag, o_res_valid, o_res_data, prev_data);
                end
            end
            i_res_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            prev_stall = 0;
            if (o_res_valid) begin
                if (i_res_ready) begin
                    checks++;
                    if (o_res_data !== pat(got) || o_res_last !== (got == d - 1)) begin
                        failures++; $display("FAIL %s result %0d: data %h last %b want %h %b",
                                             tag, got, o_res_data, o_res_last, pat(got), got == d - 1);
                    end
                    got++;
                end else begin
                    prev_stall = 1; prev_data = o_res_data;
                end
            end
            @(negedge clk); guard++;
        end
        i_res_ready = 1'b0; i_ctx_s_valid = 1'b0;
        checks++;
        if (got != d) begin
            failures++; $display("FAIL %s result count: got %0d want %0d", tag, got, d);
        end
        checks++;
        if ({o_busy, o_cfg_ready, o_res_valid} !== 3'b010) begin
            failures++; $display("FAIL %s end: busy/ready/valid got %b%b%b want 010",
                                 tag, o_busy, o_cfg_ready, o_res_valid);
        end
        checks++;
        if (ctx_n - c0 != ins || ctx_bad != 0) begin
            failures++; $display("FAIL %s ctx writes: got %0d (en/wea skew %0d) want %0d", tag, ctx_n - c0, ctx_bad, ins);
        end
        for (int i = 0; i < ins && i < ctx_n - c0; i++) begin
            checks++;
            if (ctx_addr_log[c0+i] !== 16'(i) || ctx_data_log[c0+i] !== ctxw(i)) begin
                failures++; $display("FAIL %s ctx word %0d: addr %0d data %h want %0d %h",
                                     tag, i, ctx_addr_log[c0+i], ctx_data_log[c0+i], i, ctxw(i));
            end
        end
        checks++;
        if (sw_n - s0 != d) begin
            failures++; $display("FAIL %s init writes: got %0d want %0d", tag, sw_n - s0, d);
        end
        for (int k = 0; k < d && k < sw_n - s0; k++) begin
            checks++;
            if (sw_addr_log[s0+k] !== 16'(k) || sw_data_log[s0+k] !== ((k == 0) ? INIT0 : 256'h0)) begin
                failures++; $display("FAIL %s init write %0d: addr %0d data %h", tag, k,
                                     sw_addr_log[s0+k], sw_data_log[s0+k]);
            end
        end
        checks++;
        if (start_n - st0 != 1 || start_qbit !== 6'(qbit)) begin
            failures++; $display("FAIL %s start: pulses %0d qbit %0d want 1 %0d",
                                 tag, start_n - st0, start_qbit, qbit);
        end
        checks++;
        if (rd_cyc - start_cyc < 50) begin
            failures++; $display("FAIL %s readback before complete: start->read %0d cycles want >=50",
                                 tag, rd_cyc - start_cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_cfg_ready, o_busy, o_cfg_err, o_ctx_s_ready, o_ctx_en, o_ctx_wea} !== 6'b100000) begin
            failures++; $display("FAIL reset flags: ready/busy/err/sready/en/wea got %b%b%b%b%b%b want 100000",
                                 o_cfg_ready, o_busy, o_cfg_err, o_ctx_s_ready, o_ctx_en, o_ctx_wea);
        end
        checks++;
        if ({o_state_ena, o_state_wea, o_qea_start, o_res_valid, o_res_last} !== 5'b0) begin
            failures++; $display("FAIL reset ctrl: ena/wea/start/valid/last got %b%b%b%b%b want 00000",
                                 o_state_ena, o_state_wea, o_qea_start, o_res_valid, o_res_last);
        end
        checks++;
        if ((|o_ctx_addr) || (|o_ctx_data) || (|o_state_addra) || (|o_state_dina)
            || (|o_qea_qbit_num) || (|o_res_data)) begin
            failures++; $display("FAIL reset buses: nonzero got %h %h %h want all 0",
                                 o_state_addra, o_qea_qbit_num, o_res_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_cfg_ready, o_busy} !== 2'b10) begin
            failures++; $display("FAIL idle after reset: ready/busy got %b%b want 10", o_cfg_ready, o_busy);
        end
    endtask

    task automatic test_main();
        run_job(8, 111, 1'b0, "main");
    endtask

    task automatic test_stall();
        run_job(8, 3, 1'b1, "stall");
    endtask

    task automatic test_reject();
        int qb [4] = '{8, 1, 19, 8};
        int in [4] = '{0, 5, 5, 65537};
        int c0 = ctx_n, s0 = sw_n, st0 = start_n;
        i_ctx_s_valid = 1'b1; i_ctx_s_data = 64'h5555_AAAA_5555_AAAA;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            i_cfg_valid = 1'b1; i_cfg_qbit_num = 6'(qb[j]); i_cfg_ins_num = 17'(in[j]);
            @(negedge clk);
            i_cfg_valid = 1'b0;
            checks++;
            if ({o_cfg_err, o_busy} !== 2'b10) begin
                failures++; $display("FAIL reject %0d err pulse: err/busy got %b%b want 10", j, o_cfg_err, o_busy);
            end
            @(negedge clk);
            checks++;
            if ({o_cfg_err, o_cfg_ready, o_busy} !== 3'b010) begin
                failures++; $display("FAIL reject %0d after: err/ready/busy got %b%b%b want 010",
                                     j, o_cfg_err, o_cfg_ready, o_busy);
            end
        end
        i_ctx_s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ctx_n != c0 || sw_n != s0 || start_n != st0) begin
            failures++; $display("FAIL reject activity: ctx %0d state %0d start %0d want 0 0 0",
                                 ctx_n - c0, sw_n - s0, start_n - st0);
        end
    endtask

    task automatic test_single();
        run_job(2, 1, 1'b0, "single");
    endtask

    task automatic test_reset_midjob();
        int guard = 0, s0, st0;
        bit found = 0;
        @(negedge clk);
        i_cfg_valid = 1'b1; i_cfg_qbit_num = 6'd8; i_cfg_ins_num = 17'd2;
        @(negedge clk);
        i_cfg_valid = 1'b0; i_ctx_s_valid = 1'b1; i_ctx_s_data = ctxw(0);
        while (!found && guard < 300) begin
            @(negedge clk); guard++;
            if (o_state_ena && o_state_wea && o_state_addra == 16'd10) found = 1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL midjob: init addr 10 not seen in %0d cycles", guard);
        end
        i_ctx_s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_cfg_ready, o_busy, o_state_ena, o_state_wea, o_qea_start, o_ctx_s_ready} !== 6'b100000) begin
            failures++; $display("FAIL midjob reset flags: ready/busy/ena/wea/start/sready got %b%b%b%b%b%b want 100000",
                                 o_cfg_ready, o_busy, o_state_ena, o_state_wea, o_qea_start, o_ctx_s_ready);
        end
        checks++;
        if ((|o_state_addra) || (|o_state_dina) || (|o_qea_qbit_num)) begin
            failures++; $display("FAIL midjob reset buses: addr %h qbit %0d want 0 0", o_state_addra, o_qea_qbit_num);
        end
        s0 = sw_n; st0 = start_n;
        repeat (4) @(negedge clk);
        checks++;
        if (sw_n != s0 || start_n != st0) begin
            failures++; $display("FAIL midjob activity in reset: writes %0d starts %0d want 0 0",
                                 sw_n - s0, start_n - st0);
        end
        rst_n = 1'b1;
        run_job(3, 4, 1'b1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_main();
        test_stall();
        test_reject();
        test_single();
        test_reset_midjob();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/qea_host_loader.md
QEA_HOST_LOADER -- requirements
Module: qea_host_loader

Interface
REQ-001 Parameter PE_NUM_WIDTH, default 2: log2 of PE count.
REQ-002 Parameter PE_NUM, default 4: processing elements, one state lane each.
REQ-003 Parameter STATE_DATA_WIDTH, default 64: one complex amplitude per lane (re in upper 32 bits, im in lower 32 bits, Q2.30).
REQ-004 Parameter STATE_ADDR_WIDTH, default 16; GATE_CONTEXT_DATA_WIDTH, default 64; GATE_CONTEXT_ADDR_WIDTH, default 16; MAX_QBIT_WIDTH, default 6.
REQ-005 clk  in  1  single clock; rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
REQ-006 i_cfg_valid  in  1, i_cfg_qbit_num  in  MAX_QBIT_WIDTH, i_cfg_ins_num  in  GATE_CONTEXT_ADDR_WIDTH+1  job request; o_cfg_ready  out  1  acceptance.
REQ-007 i_ctx_s_valid  in  1, i_ctx_s_data  in  GATE_CONTEXT_DATA_WIDTH; o_ctx_s_ready  out  1  context word stream.
REQ-008 o_ctx_en, o_ctx_wea  out  1; o_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH; o_ctx_data  out  GATE_CONTEXT_DATA_WIDTH  to QEA context port.
REQ-009 o_state_ena, o_state_wea  out  1; o_state_addra  out  STATE_ADDR_WIDTH; o_state_dina  out  PE_NUM*STATE_DATA_WIDTH  to QEA state port; i_state_dout  in  PE_NUM*STATE_DATA_WIDTH.
REQ-010 o_qea_start  out  1; o_qea_qbit_num  out  MAX_QBIT_WIDTH; i_qea_complete  in  1.
REQ-011 o_res_valid  out  1, o_res_data  out  PE_NUM*STATE_DATA_WIDTH, o_res_last  out  1; i_res_ready  in  1  result stream.
REQ-012 o_busy  out  1; o_cfg_err  out  1  one-cycle pulse.

Function
REQ-013 States: IDLE, LOAD_CTX, INIT_STATE, START, RUN, RD_REQ, RD_WAIT, RD_OUT; encoding is free.
REQ-014 IDLE: o_cfg_ready=1; on i_cfg_valid latch qbit_num and ins_num; depth D = 2^(qbit_num-PE_NUM_WIDTH).
REQ-015 Reject the job (o_cfg_err pulse, stay IDLE) if ins_num==0, ins_num>2^GATE_CONTEXT_ADDR_WIDTH, qbit_num<PE_NUM_WIDTH, or qbit_num>STATE_ADDR_WIDTH+PE_NUM_WIDTH; otherwise go to LOAD_CTX.
REQ-016 LOAD_CTX: o_ctx_s_ready=1; each ctx handshake drives o_ctx_en=o_ctx_wea=1 for exactly that cycle, o_ctx_data=word, o_ctx_addr=0,1,2... with no gaps or repeats under stalls; after ins_num words go to INIT_STATE.
REQ-017 INIT_STATE: D back-to-back cycles with o_state_ena=o_state_wea=1, addr 0..D-1; addr 0 data has lane PE_NUM-1 = 0x40000000_00000000 (|0>=1.0) and all other lanes 0; every other address is all zero.
REQ-018 START: o_qea_start=1 for exactly one cycle; o_qea_qbit_num holds the latched value from acceptance until return to IDLE.
REQ-019 RUN: wait for i_qea_complete==1 (level), ignoring it in the first cycle after START.
REQ-020 Readback for a=0..D-1: RD_REQ drives o_state_ena=1, o_state_wea=0, addr=a; RD_WAIT covers one cycle of RAM latency; RD_OUT captures i_state_dout into a holding register and holds o_res_valid until i_res_ready.
REQ-021 o_res_data stays stable while o_res_valid && !i_res_ready; o_res_last=1 on a=D-1; the last handshake returns to IDLE.
REQ-022 o_busy=1 in every state except IDLE; o_cfg_ready=0 whenever busy.
REQ-023 o_ctx_s_ready=0 outside LOAD_CTX; ctx words presented then are not consumed.
REQ-024 Wrap: address counters are one bit wider than the port, so D=2^STATE_ADDR_WIDTH terminates without aliasing.

Reset
REQ-025 While rst_n=0: state IDLE; every output 0 except o_cfg_ready=1; counters and latched config 0.
REQ-026 Reset mid-job aborts at once with no further RAM write or start pulse; the partial QEA contents are don't-care.

Structure
REQ-027 A shared package qea_pkg holds the FSM state type, the Q2.30 ONE constant (0x40000000), and the width parameters.
REQ-028 One sub-module, qea_res_holdreg (a one-entry valid/ready holding register), implements REQ-020/REQ-021; the rest is a single FSM plus counters.

Verification
REQ-029 qbit=8, ins=111 from a random-stall source -> 111 ctx writes at addr 0..110 with exact data; 64 init writes; one start pulse.
REQ-030 QEA model asserts complete 50 cycles after start; i_res_ready tied 1 -> 64 results, o_res_last only on the 64th; o_busy falls the cycle after.
REQ-031 i_res_ready toggled randomly -> o_res_data never changes while stalled; order addr 0..63 preserved.
REQ-032 ins=0, then qbit=1, then qbit=19 -> each gives one o_cfg_err pulse; no ctx/state/start activity.
REQ-033 qbit=2 (D=1) -> single init write with 0x40000000_00000000 in the top lane; single result with last=1.
REQ-034 rst_n low during INIT_STATE at addr 10 -> all outputs at reset values; a fresh job then completes normally.
